// File: rtl/out_signature_misr_if.sv
// Port bundle for the output-signature MISR: capture control and monitored bus in, status and signature out.
interface out_signature_misr_if #(
    parameter int DATA_W = 159,
    parameter int SIG_W  = 32,
    parameter int CNT_W  = 16
);
    // data_valid qualifies data_in on every clock; there is no ready, the MISR accepts every valid sample.
    // start is a one-cycle pulse, honoured only while busy is low.
    logic              start;
    logic [CNT_W-1:0]  skip_cycles;
    logic [CNT_W-1:0]  num_cycles;
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic [SIG_W-1:0]  signature;
    logic [CNT_W-1:0]  sample_count;
    logic [1:0]        state;

    modport master (
        output start, skip_cycles, num_cycles, data_valid, data_in,
        input  busy, done, signature, sample_count, state
    );

    modport slave (
        input  start, skip_cycles, num_cycles, data_valid, data_in,
        output busy, done, signature, sample_count, state
    );
endinterface

// File: rtl/out_signature_misr.sv
// Compresses a programmed window of valid bus samples into a MISR signature.
// The bus is XOR-folded to signature width, then clocked into a Galois-style MISR.
module out_signature_misr #(
    parameter int               DATA_W = 159,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF,
    parameter int               CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    out_signature_misr_if.slave  bus
);
    localparam int CHUNKS = (DATA_W + SIG_W - 1) / SIG_W;
    localparam int K      = CHUNKS * SIG_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SKIP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] skip_left;
    logic [CNT_W-1:0] num_limit;

    logic [K-1:0]     padded;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_step;
    logic             accept_start;

    always_comb begin
        padded               = '0;
        padded[DATA_W-1:0]   = bus.data_in;
        fold                 = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            fold = fold ^ padded[c*SIG_W +: SIG_W];
        end
    end

    assign sig_step     = {signature[SIG_W-2:0], 1'b0}
                        ^ (signature[SIG_W-1] ? POLY : '0)
                        ^ fold;
    assign accept_start = bus.start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            signature    <= '0;
            sample_count <= '0;
            skip_left    <= '0;
            num_limit    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // The sample presented alongside start is never captured.
                    if (accept_start) begin
                        signature    <= SEED;
                        sample_count <= '0;
                        skip_left    <= bus.skip_cycles;
                        num_limit    <= bus.num_cycles;
                        if (bus.skip_cycles != '0)
                            state <= S_SKIP;
                        else if (bus.num_cycles != '0)
                            state <= S_RUN;
                        else
                            state <= S_DONE;
                    end
                end
                S_SKIP: begin
                    if (bus.data_valid) begin
                        skip_left <= skip_left - 1'b1;
                        if (skip_left == {{(CNT_W-1){1'b0}}, 1'b1})
                            state <= (num_limit != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (bus.data_valid) begin
                        signature    <= sig_step;
                        sample_count <= sample_count + 1'b1;
                        if ((sample_count + 1'b1) == num_limit)
                            state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = (state == S_SKIP) || (state == S_RUN);
    assign bus.done         = (state == S_DONE);
    assign bus.signature    = signature;
    assign bus.sample_count = sample_count;
    assign bus.state        = state;
endmodule
